l2_cache_sweep_engine: RTL
==========================

L2_CACHE_SWEEP_ENGINE -- requirements
Module: l2_cache_sweep_engine

Interface
REQ-001 Parameter NUM_SETS, default 256, number of L2 sets; SHALL be a power of two.
REQ-002 Parameter NUM_WAYS, default 8, number of L2 ways.
REQ-003 Parameter TAG_WIDTH, default 18, tag width in bits; SW = $clog2(NUM_SETS) is the set index width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start_en  input  1  pulse to begin a sweep; ignored while busy=1.
REQ-007 start_invalidate  input  1  sampled with start_en: 0 = flush only (clean dirty lines), 1 = flush and invalidate.
REQ-008 busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-009 done  output  1  single-cycle pulse when the sweep completes.
REQ-010 lookup_req  output  1  request a metadata read of lookup_set from the tag arbiter.
REQ-011 lookup_set  output  SW  set index being read.
REQ-012 lookup_grant  input  1  arbiter accepts the lookup this cycle.
REQ-013 tag_valid / tag_value / tag_dirty  input  NUM_WAYS x (1 / TAG_WIDTH / 1)  per-way metadata, valid exactly one cycle after the grant cycle.
REQ-014 wb_valid  output  1  writeback request; wb_addr = {tag, set} (TAG_WIDTH+SW bits).
REQ-015 wb_ready  input  1  writeback accepted when wb_valid && wb_ready.
REQ-016 update_dirty_en  output  NUM_WAYS  one-hot dirty-array write strobe; update_dirty_set (SW), update_dirty_value (1, always 0).
REQ-017 update_tag_en  output  NUM_WAYS  one-hot tag-array write strobe; update_tag_set (SW), update_tag_valid (1, always 0), update_tag_value (TAG_WIDTH).

Function
REQ-018 States SHALL be IDLE, LOOKUP, CAPTURE, SCAN, WRITEBACK, DONE.
REQ-019 IDLE: start_en=1 -> latch mode, set counter=0, way counter=0, go LOOKUP, busy=1 next cycle.
REQ-020 LOOKUP: assert lookup_req with lookup_set=set counter; hold until lookup_grant=1; then go CAPTURE.
REQ-021 CAPTURE: register all per-way tag_valid/tag_value/tag_dirty inputs in this cycle (one cycle after grant); go SCAN with way=0.
REQ-022 SCAN, one way per cycle from captured copy: valid&&dirty -> go WRITEBACK; otherwise apply REQ-024 for this way and advance.
REQ-023 WRITEBACK: assert wb_valid with wb_addr={captured tag[way], set}; hold wb_valid and wb_addr stable until wb_ready; handshake cycle pulses update_dirty_en[way]=1, update_dirty_value=0, update_dirty_set=set, applies REQ-024, advances.
REQ-024 Invalidate mode and captured valid[way]=1 -> pulse update_tag_en[way]=1, update_tag_valid=0, update_tag_value=captured tag, update_tag_set=set; flush mode never asserts update_tag_en.
REQ-025 Advance: way < NUM_WAYS-1 -> way+1, stay/return SCAN; last way and set < NUM_SETS-1 -> set+1, LOOKUP; last way of last set -> DONE.
REQ-026 DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
REQ-027 Update strobes SHALL be at most one-hot and only for a single cycle per way; no strobes outside SCAN/WRITEBACK.
REQ-028 Sweep uses captured metadata only; arrays are not re-read during SCAN of the same set.
REQ-029 start_en while busy SHALL have no effect; start_en in the DONE cycle is ignored.
REQ-030 Counters SHALL not wrap: set counter stops at NUM_SETS-1, way counter at NUM_WAYS-1.
REQ-031 Minimum sweep length with no dirty lines and immediate grant: NUM_SETS x (2 + NUM_WAYS) cycles + 1 DONE cycle.

Reset
REQ-032 On reset, SHALL enter IDLE; busy, done, lookup_req, wb_valid, update_dirty_en, update_tag_en = 0; counters and mode = 0.
REQ-033 Reset asserted mid-sweep SHALL abort immediately with no further strobes; no done pulse for the aborted sweep.

Verification
REQ-034 NUM_SETS=4, NUM_WAYS=2, all lines clean/invalid, flush mode, grant always 1 -> no wb_valid, no strobes, done at cycle 17 after start.
REQ-035 Set 2 way 1 valid, dirty, tag 0x155, flush mode -> one wb_valid with wb_addr={0x155,2}; on handshake update_dirty_en=2'b10, update_dirty_set=2; no update_tag_en.
REQ-036 Same as REQ-035 in invalidate mode, plus set 0 way 0 valid clean tag 0x3 -> update_tag_en=2'b01 set 0 value 0x3; update_tag_en=2'b10 set 2 with dirty strobe in same cycle.
REQ-037 wb_ready held 0 for 5 cycles -> wb_valid and wb_addr stable 5 cycles, counters frozen, single dirty strobe on cycle 6.
REQ-038 lookup_grant withheld 3 cycles, then start_en pulsed while busy -> lookup_req held, lookup_set unchanged, second start ignored, exactly one done.
REQ-039 reset asserted during WRITEBACK -> all outputs 0 next edge, state IDLE, no done; fresh start_en afterwards sweeps from set 0.

Source files
------------

// File: rtl/l2_cache_sweep_engine.sv
// l2_cache_sweep_engine: walks every L2 set and way, writing back dirty lines and optionally invalidating them
module l2_cache_sweep_engine #(
    parameter int NUM_SETS  = 256,
    parameter int NUM_WAYS  = 8,
    parameter int TAG_WIDTH = 18,
    localparam int SW = $clog2(NUM_SETS),
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_en,
    input  logic                               start_invalidate,
    output logic                               busy,
    output logic                               done,
    output logic                               lookup_req,
    output logic [SW-1:0]                      lookup_set,
    input  logic                               lookup_grant,
    input  logic [NUM_WAYS-1:0]                tag_valid,
    input  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tag_value,
    input  logic [NUM_WAYS-1:0]                tag_dirty,
    output logic                               wb_valid,
    output logic [TAG_WIDTH+SW-1:0]            wb_addr,
    input  logic                               wb_ready,
    output logic [NUM_WAYS-1:0]                update_dirty_en,
    output logic [SW-1:0]                      update_dirty_set,
    output logic                               update_dirty_value,
    output logic [NUM_WAYS-1:0]                update_tag_en,
    output logic [SW-1:0]                      update_tag_set,
    output logic                               update_tag_valid,
    output logic [TAG_WIDTH-1:0]               update_tag_value
);
    typedef enum logic [2:0] {IDLE, LOOKUP, CAPTURE, SCAN, WRITEBACK, DONE} state_t;
    state_t state, state_next;
    logic [SW-1:0] set_cnt, set_next;
    logic [WW-1:0] way_cnt, way_next;
    logic inv, inv_next;
    logic [NUM_WAYS-1:0] cap_valid, cap_dirty, way_hot;
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] cap_tag;
    logic last_way, last_set, line_dirty, advance;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            set_cnt   <= '0;
            way_cnt   <= '0;
            inv       <= 1'b0;
            cap_valid <= '0;
            cap_dirty <= '0;
            cap_tag   <= '0;
        end else begin
            state   <= state_next;
            set_cnt <= set_next;
            way_cnt <= way_next;
            inv     <= inv_next;
            if (state == CAPTURE) begin
                cap_valid <= tag_valid;
                cap_dirty <= tag_dirty;
                cap_tag   <= tag_value;
            end
        end
    end
    assign way_hot    = NUM_WAYS'(1) << way_cnt;
    assign last_way   = way_cnt == WW'(NUM_WAYS - 1);
    assign last_set   = set_cnt == SW'(NUM_SETS - 1);
    assign line_dirty = cap_valid[way_cnt] && cap_dirty[way_cnt];
    // a way retires either straight from SCAN or on the writeback handshake
    assign advance    = (state == SCAN && !line_dirty) || (state == WRITEBACK && wb_ready);
    always_comb begin
        state_next = state;
        set_next   = set_cnt;
        way_next   = way_cnt;
        inv_next   = inv;
        case (state)
            IDLE: if (start_en) begin
                state_next = LOOKUP;
                set_next   = '0;
                way_next   = '0;
                inv_next   = start_invalidate;
            end
            LOOKUP:  if (lookup_grant) state_next = CAPTURE;
            CAPTURE: begin
                state_next = SCAN;
                way_next   = '0;
            end
            SCAN:    if (line_dirty) state_next = WRITEBACK;
            DONE:    state_next = IDLE;
            default: state_next = state;
        endcase
        if (advance) begin
            state_next = last_way ? (last_set ? DONE : LOOKUP) : SCAN;
            way_next   = last_way ? way_cnt : way_cnt + 1'b1;
            set_next   = (last_way && !last_set) ? set_cnt + 1'b1 : set_cnt;
        end
    end
    assign busy               = state != IDLE;
    assign done               = state == DONE;
    assign lookup_req         = state == LOOKUP;
    assign lookup_set         = set_cnt;
    assign wb_valid           = state == WRITEBACK;
    assign wb_addr            = {cap_tag[way_cnt], set_cnt};
    assign update_dirty_en    = (state == WRITEBACK && wb_ready) ? way_hot : '0;
    assign update_dirty_set   = set_cnt;
    assign update_dirty_value = 1'b0;
    assign update_tag_en      = (advance && inv && cap_valid[way_cnt]) ? way_hot : '0;
    assign update_tag_set     = set_cnt;
    assign update_tag_valid   = 1'b0;
    assign update_tag_value   = cap_tag[way_cnt];
endmodule
